// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// otter package: shared types for the Otter core's execute datapath.
//
// Contents
//   word_t           32-bit datapath word
//   aluFunc_t        ALU operation select (4-bit encoding used by ALU)
//   ALU_ARB_MAX_REQ  largest requester count alu_arbiter supports
//   ALU_BAD_FUNC     value ALU returns for an unused aluFunc_t encoding
//   arb_idx_width()  index width needed to address a given requester count
//
// Imported by ALU, rr_picker and alu_arbiter.
// ----------------------------------------------------------------------------
package otter;

    typedef logic [31:0] word_t;

    // Encoding follows the RV32I funct7[5]/funct3 packing the decoder emits.
    // Encodings not listed here are legal on the wire and decode to
    // ALU_BAD_FUNC inside the ALU.
    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SLL  = 4'b0001,
        SLT  = 4'b0010,
        SLTU = 4'b0011,
        XOR  = 4'b0100,
        SRL  = 4'b0101,
        OR   = 4'b0110,
        AND  = 4'b0111,
        SUB  = 4'b1000,
        LUI  = 4'b1001,
        SRA  = 4'b1101
    } aluFunc_t;

    localparam int    ALU_ARB_MAX_REQ = 4;
    localparam word_t ALU_BAD_FUNC    = 32'hDEAD_BEEF;

    // Width of an index able to name every one of num_req requesters; never
    // narrower than one bit so a two-requester build still has a real vector.
    function automatic int arb_idx_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ALU.sv
// ----------------------------------------------------------------------------
// ALU: combinational 32-bit integer ALU of the Otter core.
//
// Ports
//   alu_fun  in   aluFunc_t  operation select
//   src_a    in   word_t     operand A
//   src_b    in   word_t     operand B (low 5 bits are the shift amount)
//   result   out  word_t     operation result; ALU_BAD_FUNC on an unused
//                            encoding
// ----------------------------------------------------------------------------
module ALU
    import otter::*;
(
    input  aluFunc_t alu_fun,
    input  word_t    src_a,
    input  word_t    src_b,
    output word_t    result
);

    logic [4:0] shamt;
    assign shamt = src_b[4:0];

    always_comb begin
        case (alu_fun)
            ADD:     result = src_a + src_b;
            SUB:     result = src_a - src_b;
            OR:      result = src_a | src_b;
            AND:     result = src_a & src_b;
            XOR:     result = src_a ^ src_b;
            SRL:     result = src_a >> shamt;
            SLL:     result = src_a << shamt;
            SLT:     result = {31'd0, $signed(src_a) < $signed(src_b)};
            SLTU:    result = {31'd0, src_a < src_b};
            SRA:     result = word_t'($signed(src_a) >>> shamt);
            LUI:     result = src_a;
            default: result = ALU_BAD_FUNC;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: combinational one-of-NUM_REQ grant selector for alu_arbiter.
//
// Build option
//   OTTER_ALU_ARB_RR_EN defined   : round-robin; the search starts one past
//                                   `last` and wraps modulo NUM_REQ.
//   OTTER_ALU_ARB_RR_EN undefined : fixed priority, lowest eligible index
//                                   wins; `last` is ignored.
//
// Parameters
//   NUM_REQ    number of requesters (2..ALU_ARB_MAX_REQ)
//
// Ports
//   elig       in   NUM_REQ  requester may be granted this cycle
//   last       in   IDX_W    index granted most recently (round-robin only)
//   grant      out  NUM_REQ  one-hot grant, zero when nothing is eligible
//   grant_idx  out  IDX_W    binary index of the granted requester
//   grant_any  out  1        some requester is granted
// ----------------------------------------------------------------------------
module rr_picker
    import otter::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = arb_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

`ifdef OTTER_ALU_ARB_RR_EN

    // Offset k = 1 is the highest-priority slot (one past the last winner);
    // offset NUM_REQ is the last winner itself, so a lone requester can be
    // granted on consecutive cycles. Indices stay constant inside the loops;
    // only the comparison against the rotated position depends on `last`.
    always_comb begin
        // NOTE: every output gets a default before the search so that no
        // path through the block leaves one unassigned (no latch inferred).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && elig[i] &&
                    (i == ((int'(last) + k) % NUM_REQ))) begin
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

`else

    // Fixed priority: the pointer is meaningless here.
    logic unused_last;
    assign unused_last = ^last;

    // Plain priority encoder: scanning downwards lets the lowest eligible
    // index overwrite any higher one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                grant_any = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: shares one ALU among NUM_REQ requesters of the multi-cycle
// Otter core (execute stage, branch-target unit, address generator, ...).
//
// Each requester issues over a valid/ready handshake; at most one operation
// is granted per cycle. The granted operation goes straight through the ALU
// and its result is registered into that requester's private response slot,
// visible the cycle after the grant. A requester may hold one unconsumed
// result; it becomes eligible again when its slot is empty or is being
// drained in the same cycle.
//
// Build option
//   OTTER_ALU_ARB_RR_EN  defined: round-robin arbitration with a last-grant
//                        pointer; undefined: fixed priority (lowest index
//                        wins), no pointer register.
//
// Parameters
//   NUM_REQ     number of requesters (2..ALU_ARB_MAX_REQ)
//
// Ports
//   clk         in   1                  rising-edge clock
//   rst         in   1                  synchronous active-high reset
//   req_valid   in   NUM_REQ            requester i presents an operation
//   req_ready   out  NUM_REQ            operation i accepted (one-hot or 0)
//   req_fun     in   NUM_REQ x aluFunc_t operation select per requester
//   req_a       in   NUM_REQ x word_t   operand A per requester
//   req_b       in   NUM_REQ x word_t   operand B per requester
//   rsp_valid   out  NUM_REQ            slot i holds an unconsumed result
//   rsp_ready   in   NUM_REQ            requester i consumes its result
//   rsp_result  out  NUM_REQ x word_t   registered result for requester i
//   busy        out  1                  any slot full or any grant now
// ----------------------------------------------------------------------------
module alu_arbiter
    import otter::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic     [NUM_REQ-1:0]    req_valid,
    output logic     [NUM_REQ-1:0]    req_ready,
    input  aluFunc_t [NUM_REQ-1:0]    req_fun,
    input  word_t    [NUM_REQ-1:0]    req_a,
    input  word_t    [NUM_REQ-1:0]    req_b,
    output logic     [NUM_REQ-1:0]    rsp_valid,
    input  logic     [NUM_REQ-1:0]    rsp_ready,
    output word_t    [NUM_REQ-1:0]    rsp_result,
    output logic                      busy
);

    localparam int IDX_W = arb_idx_width(NUM_REQ);

    // ------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   last;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;

    // A full slot that is being drained this cycle frees up in time for a
    // new result, which is what allows back-to-back issue per requester.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    rr_picker #(
        .NUM_REQ   (NUM_REQ)
    ) u_picker (
        .elig      (elig),
        .last      (last),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Nothing is accepted while reset is asserted, so an operation offered
    // in a reset cycle is never acknowledged and never lands in a slot.
    assign grant     = rst ? '0 : pick_grant;
    assign grant_any = ~rst & pick_any;
    assign req_ready = grant;

`ifdef OTTER_ALU_ARB_RR_EN
    // Reset value NUM_REQ-1 makes requester 0 the first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IDX_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            last <= pick_idx;
        end
    end
`else
    assign last = '0;
`endif

    // ------------------------------------------------------------------
    // Shared ALU
    // ------------------------------------------------------------------
    aluFunc_t alu_fun;
    word_t    alu_a;
    word_t    alu_b;
    word_t    alu_result;

    // One-hot AND-OR style mux; idle cycles present ADD 0,0 so the ALU
    // inputs do not toggle with requesters that were not granted.
    always_comb begin
        alu_fun = ADD;
        alu_a   = '0;
        alu_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_fun = req_fun[i];
                alu_a   = req_a[i];
                alu_b   = req_b[i];
            end
        end
    end

    ALU u_alu (
        .alu_fun (alu_fun),
        .src_a   (alu_a),
        .src_b   (alu_b),
        .result  (alu_result)
    );

    // ------------------------------------------------------------------
    // Response slots
    // ------------------------------------------------------------------
    // Per slot: EMPTY -> FULL on grant; FULL -> EMPTY on drain without a
    // grant; otherwise FULL stays FULL (a same-cycle drain + grant simply
    // overwrites the data). A drain request on an empty slot is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the result registers are cleared as well as the valid
            // bits, because consumers may observe rsp_result straight after
            // reset and expect zero rather than stale data.
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                // NOTE: non-blocking assignments keep every slot update
                // based on start-of-cycle state, independent of loop order.
                if (grant[i]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_result[i] <= alu_result;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    assign busy = (|rsp_valid) | grant_any;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter: self-checking bench for alu_arbiter (NUM_REQ = 2).
// Directed scenarios followed by a random phase; a cycle-level reference
// model predicts the grant, busy and slot state, and per-requester queues
// hold the expected results until the DUT presents them.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
    import otter::*;

    localparam int N = 2;

    logic                clk;
    logic                rst;
    logic     [N-1:0]    req_valid;
    logic     [N-1:0]    req_ready;
    aluFunc_t [N-1:0]    req_fun;
    word_t    [N-1:0]    req_a;
    word_t    [N-1:0]    req_b;
    logic     [N-1:0]    rsp_valid;
    logic     [N-1:0]    rsp_ready;
    word_t    [N-1:0]    rsp_result;
    logic                busy;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fun    (req_fun),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [N-1:0] m_valid;
    int           m_last;
    word_t        sb [N][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic word_t alu_model(input logic [3:0] f, input word_t a, input word_t b);
        case (f)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h6: return a | b;
            4'h7: return a & b;
            4'h4: return a ^ b;
            4'h5: return a >> b[4:0];
            4'h1: return a << b[4:0];
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'hD: return word_t'($signed(a) >>> b[4:0]);
            4'h9: return a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Two-requester arbitration written out case by case.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] e, input int last);
`ifdef OTTER_ALU_ARB_RR_EN
        if (last == 1) begin
            if (e[0]) return 2'b01;
            if (e[1]) return 2'b10;
        end else begin
            if (e[1]) return 2'b10;
            if (e[0]) return 2'b01;
        end
        return 2'b00;
`else
        if (e[0]) return 2'b01;
        if (e[1]) return 2'b10;
        return 2'b00;
`endif
    endfunction

    // One clock cycle: inputs already driven by the caller. Compares the
    // combinational and registered outputs with the model, advances the
    // model, then moves to just after the next rising edge.
    task automatic cycle();
        logic [N-1:0] e;
        logic [N-1:0] exp_grant;
        #1;
        exp_grant = '0;
        if (!rst) begin
            e = req_valid & (~m_valid | rsp_ready);
            exp_grant = model_pick(e, m_last);
        end
        check("req_ready", 32'(req_ready), 32'(exp_grant));
        check("busy", 32'(busy), 32'((|m_valid) | (|exp_grant)));
        for (int i = 0; i < N; i++) begin
            check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
            if (m_valid[i])
                check($sformatf("rsp_result[%0d]", i), rsp_result[i], sb[i][0]);
        end
        if (rst) begin
            m_valid = '0;
            m_last  = N - 1;
            for (int i = 0; i < N; i++) sb[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && rsp_ready[i]) void'(sb[i].pop_front());
                if (exp_grant[i]) begin
                    sb[i].push_back(alu_model(4'(req_fun[i]), req_a[i], req_b[i]));
                    m_last = i;
                end
                m_valid[i] = exp_grant[i] | (m_valid[i] & ~rsp_ready[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r);
        req_valid = v;
        rsp_ready = r;
    endtask

    task automatic set_op(input int i, input aluFunc_t f, input word_t a, input word_t b);
        req_fun[i] = f;
        req_a[i]   = a;
        req_b[i]   = b;
    endtask

    logic [N-1:0] exp_pat [4];

    initial begin
        m_valid = '0;
        m_last  = N - 1;
        rst = 1'b1;
        drive(2'b00, 2'b00);
        set_op(0, ADD, 0, 0);
        set_op(1, ADD, 0, 0);
        @(posedge clk);
        #1;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_result0", rsp_result[0], 32'h0);
        check("reset_result1", rsp_result[1], 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Single request: ADD 5,7
        set_op(0, ADD, 32'd5, 32'd7);
        drive(2'b01, 2'b00);
        #1;
        check("add_ready", 32'(req_ready), 32'h1);
        cycle();
        drive(2'b00, 2'b01);
        check("add_valid", 32'(rsp_valid), 32'h1);
        check("add_result", rsp_result[0], 32'd12);
        cycle();

        // Both requesters continuously valid, draining every cycle
`ifdef OTTER_ALU_ARB_RR_EN
        exp_pat = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_pat = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1;
        drive(2'b00, 2'b00);
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_op(0, XOR, word_t'(32'h1111_0000 + c), 32'h0000_FFFF);
            set_op(1, SLL, word_t'(c + 1), 32'd3);
            drive(2'b11, 2'b11);
            #1;
            check($sformatf("alt_grant%0d", c), 32'(req_ready), 32'(exp_pat[c]));
            cycle();
        end
        drive(2'b00, 2'b11);
        cycle();

        // Slot 0 full and not drained: requester 1 wins
        set_op(0, ADD, 32'd1, 32'd1);
        drive(2'b01, 2'b00);
        cycle();
        set_op(0, SUB, 32'd3, 32'd5);
        set_op(1, ADD, 32'd2, 32'd2);
        drive(2'b11, 2'b00);
        #1;
        check("full_blocks0", 32'(req_ready), 32'h2);
        cycle();
        drive(2'b01, 2'b11);
        #1;
        check("drain_issue0", 32'(req_ready), 32'h1);
        cycle();
        check("sub_valid0", 32'(rsp_valid[0]), 32'h1);
        check("sub_result", rsp_result[0], 32'hFFFF_FFFE);
        drive(2'b00, 2'b11);
        cycle();

        // Same-cycle drain and issue on requester 1: SRA
        set_op(1, ADD, 32'd1, 32'd2);
        drive(2'b10, 2'b00);
        cycle();
        set_op(1, SRA, 32'h8000_0000, 32'd4);
        drive(2'b10, 2'b10);
        #1;
        check("sra_ready", 32'(req_ready), 32'h2);
        cycle();
        check("sra_valid1", 32'(rsp_valid[1]), 32'h1);
        check("sra_result", rsp_result[1], 32'hF800_0000);
        drive(2'b00, 2'b11);
        cycle();

        // Unused function encoding
        set_op(0, aluFunc_t'(4'hF), 32'h1234_5678, 32'h1);
        drive(2'b01, 2'b00);
        cycle();
        check("bad_func", rsp_result[0], 32'hDEAD_BEEF);
        drive(2'b00, 2'b11);
        cycle();

        // Reset asserted in a cycle that would grant
        set_op(0, OR, 32'hF0, 32'h0F);
        set_op(1, AND, 32'hFF, 32'h3C);
        drive(2'b11, 2'b00);
        cycle();
        rst = 1'b1;
        drive(2'b11, 2'b00);
        cycle();
        rst = 1'b0;
        drive(2'b00, 2'b00);
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_result0", rsp_result[0], 32'h0);
        check("rst_mid_result1", rsp_result[1], 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        drive(2'b11, 2'b00);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        cycle();

        // Random traffic, occasional reset
        for (int c = 0; c < 400; c++) begin
            logic [3:0] f;
            rst = ($urandom_range(0, 59) == 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                f = 4'($urandom_range(0, 15));
                req_fun[i] = aluFunc_t'(f);
                req_a[i]   = $urandom;
                req_b[i]   = ($urandom_range(0, 1) == 1) ? word_t'($urandom_range(0, 40)) : $urandom;
            end
            cycle();
        end
        rst = 1'b0;
        drive(2'b00, 2'b11);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
